sprite_line_buffer: RTL and testbench
=====================================

Name: sprite_line_buffer

Overview:
- Double-buffered sprite line buffer; sits directly downstream of the sprite address generator / sprite ROM fetch path.
- During line N it accepts sprite pixels for line N+1 at an X position loaded by HSET. In parallel it streams line N to the video mixer and clears each location after reading it.
- Banks swap on each falling edge of nHSYNC.

Parameters:
- ADDR_W, 9, line address width (512 locations, wraps mod 2^ADDR_W).
- PIX_W, 8, stored pixel width (upper nibble palette bank, lower nibble colour index).
- TRANSP, 4'hF, colour index (low nibble) treated as transparent and used as clear value.

Ports:
- CLK_6M  in  1  pixel clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- nHSYNC  in  1  horizontal sync; falling edge swaps banks.
- HSET  in  1  load write X from X_IN this cycle.
- X_IN  in  ADDR_W  sprite start X.
- HFLIP  in  1  1 = write address decrements per pixel, 0 = increments.
- PIX_VALID  in  1  write-side pixel strobe.
- PIX  in  PIX_W  write-side pixel.
- RD_EN  in  1  active-display read strobe.
- PIX_OUT  out  PIX_W  read-side pixel, registered.
- PIX_OUT_VALID  out  1  PIX_OUT qualifier.
- BANK  out  1  current write bank index; the read bank is ~BANK.

Behaviour:
- Reset (async, rst_n low):
  - BANK=0, wr_x=0, rd_x=0, nHSYNC edge register=1.
  - PIX_OUT={PIX_W-4 zeros,TRANSP}, PIX_OUT_VALID=0.
  - Memory contents are not reset. The bench must run one full line before checking output.
- Swap:
  - Falling edge detected synchronously: hs_d=1 and nHSYNC=0.
  - In that cycle, BANK toggles at the clock edge and rd_x<=0.
  - Writes and reads in the swap cycle use the pre-swap bank.
  - wr_x is unchanged by the swap.
- Write side:
  - If HSET: this cycle's pixel (when PIX_VALID) goes to X_IN, and wr_x<=X_IN+1 (HFLIP=0) or X_IN-1 (HFLIP=1).
  - Else, if PIX_VALID: the pixel goes to wr_x, and wr_x steps ±1.
  - HSET without PIX_VALID loads X_IN (no ±1) and writes nothing.
  - Address arithmetic is mod 2^ADDR_W: 511+1=0, 0-1=511.
  - A pixel whose low nibble is TRANSP is never written, but wr_x still steps.
  - Default (feature off): a later pixel overwrites an earlier one at the same X.
- Read side:
  - When RD_EN: PIX_OUT<=mem[~BANK][rd_x] and PIX_OUT_VALID<=1 on the next edge (latency 1). In the same cycle mem[~BANK][rd_x]<=clear value (read-first), and rd_x<=rd_x+1 with wrap.
  - When RD_EN=0: PIX_OUT<=clear value, PIX_OUT_VALID<=0, no clear, rd_x holds.
- Clear value: {PIX_W-4 zeros, TRANSP}.
- Write and read never address the same bank, so there are no collisions.
- Reset mid-line: all state returns to reset values immediately. A partially written line is garbage until rewritten; no lockup.

Optional Feature:
- Macro SPRITE_LB_PRIORITY_EN.
- Defined: a write occurs only if the existing location's low nibble == TRANSP, so the first-drawn sprite wins. This needs a same-cycle combinational read on the write port.
- Undefined: unconditional overwrite of non-transparent pixels, as described above.

Decomposition:
- Package sprite_lb_pkg: ADDR_W and PIX_W defaults, TRANSP, the clear-value constant, and a function is_transp(pix).
- Sub-module sprite_lb_bank: one 2^ADDR_W x PIX_W dual-port bank.
  - Port A: write with optional combinational read, for priority mode.
  - Port B: read-first with simultaneous clear.
  - Instantiated twice; BANK steers the ports.

Test Plan:
- Basic: HSET X_IN=16, HFLIP=0, four pixels 0x21,0x22,0x23,0x24; falling nHSYNC; RD_EN from rd_x 0 -> PIX_OUT 0x21..0x24 on the cycles after rd_x=16..19 are presented, clear value elsewhere.
- Flip/wrap: HSET X_IN=1, HFLIP=1, pixels 0x31,0x32,0x33 -> written at X=1,0,511. Also HSET X_IN=510, HFLIP=0, three pixels -> X=510,511,0.
- Transparency: pixel stream 0x41,0x4F,0x43 from X=100 -> X=101 stays clear value, X=102=0x43.
- Clear-after-read: read a line containing 0x21 at X=16, swap twice with no writes -> X=16 reads back the clear value.
- Overlap:
  - Sprite A 0x51 at X=50, then sprite B 0x62 at X=50 -> read 0x62 (feature off) or 0x51 (SPRITE_LB_PRIORITY_EN).
- Reset mid-line: assert rst_n low during a pixel stream -> PIX_OUT_VALID=0, BANK=0, PIX_OUT=clear value immediately. After release, a full line write/read cycle passes the Basic check.

Source files
------------

// File: rtl/sprite_lb_pkg.sv
// Shared constants and helpers for the sprite line buffer.
package sprite_lb_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned PIX_W_DEF  = 8;

  // Low-nibble colour index that means "no pixel"; also the cleared state of a location.
  localparam logic [3:0] TRANSP = 4'hF;

  localparam logic [PIX_W_DEF-1:0] CLR_VAL = {{(PIX_W_DEF - 4){1'b0}}, TRANSP};

  function automatic logic is_transp(input logic [3:0] pix);
    return pix == TRANSP;
  endfunction

endpackage

// File: rtl/sprite_lb_bank.sv
// One line bank: port A writes sprite pixels, port B reads for display and clears behind itself.
// Build option SPRITE_LB_PRIORITY_EN: port A only writes onto a transparent location, so the
// first sprite drawn at an X keeps it.
module sprite_lb_bank
  import sprite_lb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF
) (
  input  logic              CLK_6M,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [PIX_W-1:0]  a_wdata,
  input  logic              b_clr,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [PIX_W-1:0]  b_rdata
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [PIX_W-1:0] ClrVal = {{(PIX_W - 4){1'b0}}, TRANSP};

  logic [PIX_W-1:0] mem [Depth];
  logic             a_we_eff;

  // Read-first: the old word leaves on b_rdata while the clear lands at the edge.
  assign b_rdata = mem[b_addr];

`ifdef SPRITE_LB_PRIORITY_EN
  // Same-cycle look at the target so an earlier opaque pixel is never overdrawn.
  assign a_we_eff = a_we & is_transp(mem[a_addr][3:0]);
`else
  assign a_we_eff = a_we;
`endif

  // Contents are deliberately not reset; a read pass clears the bank.
  always_ff @(posedge CLK_6M) begin
    if (a_we_eff) mem[a_addr] <= a_wdata;
    if (b_clr)    mem[b_addr] <= ClrVal;
  end

endmodule

// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite line buffer: one bank collects the next line's sprites while the other
// is streamed to the mixer and cleared. Banks swap on each falling edge of nHSYNC.
// Build option SPRITE_LB_PRIORITY_EN (handled in sprite_lb_bank): first-drawn sprite wins.
module sprite_line_buffer
  import sprite_lb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF
) (
  input  logic              CLK_6M,
  input  logic              rst_n,
  input  logic              nHSYNC,
  input  logic              HSET,
  input  logic [ADDR_W-1:0] X_IN,
  input  logic              HFLIP,
  input  logic              PIX_VALID,
  input  logic [PIX_W-1:0]  PIX,
  input  logic              RD_EN,
  output logic [PIX_W-1:0]  PIX_OUT,
  output logic              PIX_OUT_VALID,
  output logic              BANK
);

  localparam logic [PIX_W-1:0] ClrVal = {{(PIX_W - 4){1'b0}}, TRANSP};

  logic              hs_q;
  logic              bank_q;
  logic [ADDR_W-1:0] wr_x_q, wr_x_d;
  logic [ADDR_W-1:0] rd_x_q, rd_x_d;
  logic [PIX_W-1:0]  pix_out_q, pix_out_d;
  logic              pix_out_valid_q, pix_out_valid_d;

  logic              swap;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  rd_data0, rd_data1, rd_data;

  assign swap    = hs_q & ~nHSYNC;
  // HSET redirects this cycle's pixel to X_IN; otherwise the running write pointer is used.
  assign wr_addr = HSET ? X_IN : wr_x_q;
  assign wr_en   = PIX_VALID & ~is_transp(PIX[3:0]);
  // Read bank is always the one not being written.
  assign rd_data = bank_q ? rd_data0 : rd_data1;

  // Write pointer: load on HSET, step from the used address on every valid pixel.
  always_comb begin
    wr_x_d = wr_x_q;
    if (HSET)      wr_x_d = X_IN;
    if (PIX_VALID) wr_x_d = HFLIP ? wr_addr - 1'b1 : wr_addr + 1'b1;
  end

  // Read side: registered pixel out, pointer advance, rewind on bank swap.
  always_comb begin
    pix_out_d       = ClrVal;
    pix_out_valid_d = 1'b0;
    rd_x_d          = rd_x_q;
    if (RD_EN) begin
      pix_out_d       = rd_data;
      pix_out_valid_d = 1'b1;
      rd_x_d          = rd_x_q + 1'b1;
    end
    if (swap) rd_x_d = '0;
  end

  // State registers.
  always_ff @(posedge CLK_6M or negedge rst_n) begin
    if (!rst_n) begin
      hs_q            <= 1'b1;
      bank_q          <= 1'b0;
      wr_x_q          <= '0;
      rd_x_q          <= '0;
      pix_out_q       <= ClrVal;
      pix_out_valid_q <= 1'b0;
    end else begin
      hs_q            <= nHSYNC;
      bank_q          <= bank_q ^ swap;
      wr_x_q          <= wr_x_d;
      rd_x_q          <= rd_x_d;
      pix_out_q       <= pix_out_d;
      pix_out_valid_q <= pix_out_valid_d;
    end
  end

  assign PIX_OUT       = pix_out_q;
  assign PIX_OUT_VALID = pix_out_valid_q;
  assign BANK          = bank_q;

  sprite_lb_bank #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_bank0 (
    .CLK_6M  (CLK_6M),
    .a_we    (wr_en & ~bank_q),
    .a_addr  (wr_addr),
    .a_wdata (PIX),
    .b_clr   (RD_EN & bank_q),
    .b_addr  (rd_x_q),
    .b_rdata (rd_data0)
  );

  sprite_lb_bank #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_bank1 (
    .CLK_6M  (CLK_6M),
    .a_we    (wr_en & bank_q),
    .a_addr  (wr_addr),
    .a_wdata (PIX),
    .b_clr   (RD_EN & ~bank_q),
    .b_addr  (rd_x_q),
    .b_rdata (rd_data1)
  );

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Self-checking bench for sprite_line_buffer: directed line scenarios plus a random phase,
// all compared cycle by cycle against a two-line array model.
module tb_sprite_line_buffer;

  localparam int N = 512;
  localparam logic [7:0] CLR = 8'h0F;

  logic       CLK_6M    = 1'b0;
  logic       rst_n     = 1'b0;
  logic       nHSYNC    = 1'b1;
  logic       HSET      = 1'b0;
  logic [8:0] X_IN      = '0;
  logic       HFLIP     = 1'b0;
  logic       PIX_VALID = 1'b0;
  logic [7:0] PIX       = '0;
  logic       RD_EN     = 1'b0;
  logic [7:0] PIX_OUT;
  logic       PIX_OUT_VALID;
  logic       BANK;

  int total = 0;
  int bad   = 0;

  // Model: line[b][x] is bank b's content; wbank is the bank being composed.
  logic [7:0] line [2][N];
  int         wbank, wx, rx;
  bit         prev_hs;
  logic [7:0] e_out;
  bit         e_valid;
  bit         chk_data;
  logic [7:0] got [N];

  always #5 CLK_6M = ~CLK_6M;

  sprite_line_buffer dut (
    .CLK_6M        (CLK_6M),
    .rst_n         (rst_n),
    .nHSYNC        (nHSYNC),
    .HSET          (HSET),
    .X_IN          (X_IN),
    .HFLIP         (HFLIP),
    .PIX_VALID     (PIX_VALID),
    .PIX           (PIX),
    .RD_EN         (RD_EN),
    .PIX_OUT       (PIX_OUT),
    .PIX_OUT_VALID (PIX_OUT_VALID),
    .BANK          (BANK)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    wbank   = 0;
    wx      = 0;
    rx      = 0;
    prev_hs = 1'b1;
  endtask

  // Apply the current inputs to the model, clock the DUT, compare just after the edge.
  task automatic cycle();
    int a;
    bit sw;
    sw = prev_hs && !nHSYNC;
    if (RD_EN) begin
      e_out          = line[1-wbank][rx];
      e_valid        = 1'b1;
      line[1-wbank][rx] = CLR;
      rx             = (rx + 1) % N;
    end else begin
      e_out   = CLR;
      e_valid = 1'b0;
    end
    if (PIX_VALID) begin
      a = HSET ? int'(X_IN) : wx;
      if (PIX[3:0] != 4'hF) begin
`ifdef SPRITE_LB_PRIORITY_EN
        if (line[wbank][a][3:0] == 4'hF) line[wbank][a] = PIX;
`else
        line[wbank][a] = PIX;
`endif
      end
      wx = HFLIP ? (a + N - 1) % N : (a + 1) % N;
    end else if (HSET) begin
      wx = int'(X_IN);
    end
    if (sw) begin
      wbank = 1 - wbank;
      rx    = 0;
    end
    prev_hs = nHSYNC;
    @(posedge CLK_6M);
    #1;
    check("bank", BANK, wbank);
    check("out_valid", PIX_OUT_VALID, e_valid);
    if (chk_data) check("pix_out", PIX_OUT, e_out);
  endtask

  task automatic hs_pulse();
    nHSYNC = 1'b0;
    cycle();
    nHSYNC = 1'b1;
    cycle();
  endtask

  task automatic read_line();
    int idx;
    RD_EN = 1'b1;
    for (int i = 0; i < N; i++) begin
      idx = rx;
      cycle();
      got[idx] = PIX_OUT;
    end
    RD_EN = 1'b0;
  endtask

  task automatic write_sprite(input int x, input bit flip, input logic [7:0] p[4], input int n);
    for (int i = 0; i < n; i++) begin
      HSET      = (i == 0);
      X_IN      = 9'(x);
      HFLIP     = flip;
      PIX_VALID = 1'b1;
      PIX       = p[i];
      cycle();
    end
    HSET      = 1'b0;
    HFLIP     = 1'b0;
    PIX_VALID = 1'b0;
  endtask

  // Compare the last read line against a picture built from explicit (x, pixel) pairs.
  task automatic check_line(input string tag, input int xs[4], input logic [7:0] vs[4],
                            input int n);
    logic [7:0] img [N];
    int nbad;
    for (int i = 0; i < N; i++) img[i] = CLR;
    for (int k = 0; k < n; k++) img[xs[k]] = vs[k];
    for (int k = 0; k < n; k++) check($sformatf("%s_x%0d", tag, xs[k]), got[xs[k]], vs[k]);
    nbad = 0;
    for (int i = 0; i < N; i++) if (got[i] !== img[i]) nbad++;
    check({tag, "_rest"}, nbad, 0);
  endtask

  initial begin
    for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) line[b][i] = CLR;
    model_reset();
    chk_data = 1'b0;

    // Reset values
    #12;
    check("rst_bank", BANK, 0);
    check("rst_valid", PIX_OUT_VALID, 0);
    check("rst_pix", PIX_OUT, CLR);
    rst_n = 1'b1;

    // Flush both banks; memory powers up unknown
    hs_pulse(); read_line();
    hs_pulse(); read_line();
    chk_data = 1'b1;

    // Basic
    write_sprite(16, 1'b0, '{8'h21, 8'h22, 8'h23, 8'h24}, 4);
    hs_pulse(); read_line();
    check_line("basic", '{16, 17, 18, 19}, '{8'h21, 8'h22, 8'h23, 8'h24}, 4);

    // Clear-after-read
    hs_pulse(); read_line();
    hs_pulse(); read_line();
    check("clr_x16", got[16], CLR);
    check_line("clr", '{0, 0, 0, 0}, '{8'h0, 8'h0, 8'h0, 8'h0}, 0);

    // Flip with wrap below zero
    write_sprite(1, 1'b1, '{8'h31, 8'h32, 8'h33, 8'h00}, 3);
    hs_pulse(); read_line();
    check_line("flip", '{1, 0, 511, 0}, '{8'h31, 8'h32, 8'h33, 8'h00}, 3);

    // Wrap above 511
    write_sprite(510, 1'b0, '{8'h34, 8'h35, 8'h36, 8'h00}, 3);
    hs_pulse(); read_line();
    check_line("wrap", '{510, 511, 0, 0}, '{8'h34, 8'h35, 8'h36, 8'h00}, 3);

    // Transparent pixel skipped but pointer still steps
    write_sprite(100, 1'b0, '{8'h41, 8'h4F, 8'h43, 8'h00}, 3);
    hs_pulse(); read_line();
    check("transp_x101", got[101], CLR);
    check_line("transp", '{100, 102, 0, 0}, '{8'h41, 8'h43, 8'h00, 8'h00}, 2);

    // Overlap
    write_sprite(50, 1'b0, '{8'h51, 8'h00, 8'h00, 8'h00}, 1);
    write_sprite(50, 1'b0, '{8'h62, 8'h00, 8'h00, 8'h00}, 1);
    hs_pulse(); read_line();
`ifdef SPRITE_LB_PRIORITY_EN
    check_line("overlap", '{50, 0, 0, 0}, '{8'h51, 8'h00, 8'h00, 8'h00}, 1);
`else
    check_line("overlap", '{50, 0, 0, 0}, '{8'h62, 8'h00, 8'h00, 8'h00}, 1);
`endif

    // Random concurrent writes, reads and swaps
    for (int i = 0; i < 1500; i++) begin
      nHSYNC    = ((i % 150) == 149) ? 1'b0 : 1'b1;
      HSET      = ($urandom_range(0, 15) == 0);
      X_IN      = 9'($urandom_range(0, N - 1));
      if (HSET) HFLIP = 1'($urandom_range(0, 1));
      PIX_VALID = 1'($urandom_range(0, 1));
      PIX       = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) PIX[3:0] = 4'hF;
      RD_EN     = 1'($urandom_range(0, 1));
      cycle();
    end
    nHSYNC = 1'b1; HSET = 1'b0; HFLIP = 1'b0; PIX_VALID = 1'b0; RD_EN = 1'b0;
    cycle();

    // Reset in the middle of a pixel stream, with BANK=1 and output valid
    if (wbank == 0) hs_pulse();
    RD_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      HSET = (i == 0); X_IN = 9'd200; PIX_VALID = 1'b1; PIX = 8'(8'h70 + i);
      cycle();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_valid", PIX_OUT_VALID, 0);
    check("midrst_bank", BANK, 0);
    check("midrst_pix", PIX_OUT, CLR);
    model_reset();
    HSET = 1'b0; PIX_VALID = 1'b0; RD_EN = 1'b0;
    #1;
    rst_n = 1'b1;

    // Full line cycle after reset
    hs_pulse(); read_line();
    hs_pulse(); read_line();
    write_sprite(16, 1'b0, '{8'h21, 8'h22, 8'h23, 8'h24}, 4);
    hs_pulse(); read_line();
    check_line("post_rst", '{16, 17, 18, 19}, '{8'h21, 8'h22, 8'h23, 8'h24}, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
